// File: rtl/req_ack_responder.sv
// req_ack_responder: responder end of a tagged single-bit request/acknowledge
// protocol. An accepted request travels through LATENCY-1 delay stages, then
// waits in an ack FIFO behind a registered ack output stage. Outstanding
// requests are bounded by MAX_OUTSTANDING, and a request seen while
// req_ready is low sets a sticky overflow flag.
//
// Handshakes: a request is accepted at a posedge where req && req_ready;
// an ack is consumed at a posedge where ack_valid && ack_ready. Once raised,
// ack_valid stays high with a stable ack_tag until consumed (or reset), and
// ack_ready is ignored while ack_valid is low.
//
// Optional feature: define REQ_ACK_RESPONDER_ASSERT_EN to compile embedded
// concurrent protocol assertions. Functional behaviour is the same either way.
module req_ack_responder #(
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_W           = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     req,
  input  logic [TAG_W-1:0]                         req_tag,
  output logic                                     req_ready,
  output logic                                     ack_valid,
  output logic [TAG_W-1:0]                         ack_tag,
  input  logic                                     ack_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
  output logic                                     overflow
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Parameter sanity, reported at elaboration.
  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("req_ack_responder: LATENCY must be >= 1 (got %0d)", LATENCY);
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_max
      $error("req_ack_responder: MAX_OUTSTANDING must be >= 1 (got %0d)", MAX_OUTSTANDING);
    end
  endgenerate

  logic             accept;
  logic             consume;
  logic             arr_vld;   // entry leaving the delay line this edge
  logic [TAG_W-1:0] arr_tag;

  logic             ack_valid_q, ack_valid_d;
  logic [TAG_W-1:0] ack_tag_q, ack_tag_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             overflow_q, overflow_d;

  logic [TAG_W-1:0] fifo_mem_q [MAX_OUTSTANDING];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             fifo_push;
  logic             fifo_pop;

  // No same-cycle credit return: readiness depends only on registered count.
  assign req_ready   = (outstanding_q < CNT_W'(MAX_OUTSTANDING));
  assign accept      = req && req_ready;
  assign consume     = ack_valid_q && ack_ready;

  assign ack_valid   = ack_valid_q;
  assign ack_tag     = ack_tag_q;
  assign outstanding = outstanding_q;
  assign overflow    = overflow_q;

  // Delay line: with LATENCY=1 an accepted tag goes straight to the ack stage.
  generate
    if (LATENCY <= 1) begin : g_direct
      assign arr_vld = accept;
      assign arr_tag = req_tag;
    end else begin : g_delay
      logic [LATENCY-2:0] vld_q;
      logic [TAG_W-1:0]   tag_q [LATENCY-1];

      // Shift accepted tags one stage per clock; reset discards in-flight tags.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < LATENCY - 1; i++) tag_q[i] <= '0;
        end else begin
          vld_q[0] <= accept;
          tag_q[0] <= req_tag;
          for (int i = 1; i < LATENCY - 1; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
          end
        end
      end

      assign arr_vld = vld_q[LATENCY-2];
      assign arr_tag = tag_q[LATENCY-2];
    end
  endgenerate

  // Ack stage refill: the FIFO head has priority over a newly arriving tag,
  // which keeps acks in accept order; arrivals queue while the stage is held.
  always_comb begin
    ack_valid_d = ack_valid_q;
    ack_tag_d   = ack_tag_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    if (!ack_valid_q || consume) begin
      if (fifo_cnt_q != '0) begin
        fifo_pop    = 1'b1;
        fifo_push   = arr_vld;
        ack_valid_d = 1'b1;
        ack_tag_d   = fifo_mem_q[rd_ptr_q];
      end else if (arr_vld) begin
        ack_valid_d = 1'b1;
        ack_tag_d   = arr_tag;
      end else begin
        ack_valid_d = 1'b0;   // tag keeps its last value while empty
      end
    end else begin
      fifo_push = arr_vld;
    end
  end

  // Counters, pointers and the sticky overflow flag.
  always_comb begin
    outstanding_d = outstanding_q;
    fifo_cnt_d    = fifo_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    overflow_d    = overflow_q || (req && !req_ready);

    case ({accept, consume})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (fifo_push) begin
      wr_ptr_d = (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_valid_q   <= 1'b0;
      ack_tag_q     <= '0;
      outstanding_q <= '0;
      overflow_q    <= 1'b0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      ack_valid_q   <= ack_valid_d;
      ack_tag_q     <= ack_tag_d;
      outstanding_q <= outstanding_d;
      overflow_q    <= overflow_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage; emptiness is tracked by the count, so no reset needed here.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q] <= arr_tag;
    end
  end

`ifdef REQ_ACK_RESPONDER_ASSERT_EN
  // Entries still inside the delay line = total - queued - presented.
  logic dl_empty;
  assign dl_empty = (outstanding_q == (fifo_cnt_q + CNT_W'(ack_valid_q)));

  a_ack_hold: assert property (@(posedge clk) disable iff (rst)
    ack_valid && !ack_ready |=> ack_valid && $stable(ack_tag))
    else $error("%m: ack not held while stalled, tag %0h", ack_tag);

  a_bound: assert property (@(posedge clk) disable iff (rst)
    outstanding <= CNT_W'(MAX_OUTSTANDING))
    else $error("%m: outstanding %0d above limit, tag %0h", outstanding, ack_tag);

  a_no_accept_full: assert property (@(posedge clk) disable iff (rst)
    !req_ready |-> !accept)
    else $error("%m: accepted while not ready, tag %0h", req_tag);

  a_latency: assert property (@(posedge clk) disable iff (rst)
    (accept && (fifo_cnt_q == '0) && dl_empty) ##0 ack_ready [*LATENCY] |=> ack_valid)
    else $error("%m: ack late after accept, tag %0h", ack_tag);
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Bench for req_ack_responder: two instances (LATENCY=1 and LATENCY=3,
// MAX_OUTSTANDING=4, TAG_W=4) share the same stimulus. A constant vector
// table and hand sequences cover the listed scenarios; a queue-based
// timestamp model checks every cycle of both instances, including a long
// randomized run.
module tb_req_ack_responder;

  localparam int TAG_W = 4;
  localparam int MAXO  = 4;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             req = 1'b0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             ack_ready = 1'b0;

  logic             rdy1, av1, ovf1, rdy3, av3, ovf3;
  logic [TAG_W-1:0] at1, at3;
  logic [2:0]       out1, out3;

  req_ack_responder #(.LATENCY(1), .MAX_OUTSTANDING(MAXO), .TAG_W(TAG_W)) dut1 (
    .clk(clk), .rst(rst), .req(req), .req_tag(req_tag), .req_ready(rdy1),
    .ack_valid(av1), .ack_tag(at1), .ack_ready(ack_ready),
    .outstanding(out1), .overflow(ovf1)
  );

  req_ack_responder #(.LATENCY(3), .MAX_OUTSTANDING(MAXO), .TAG_W(TAG_W)) dut3 (
    .clk(clk), .rst(rst), .req(req), .req_tag(req_tag), .req_ready(rdy3),
    .ack_valid(av3), .ack_tag(at3), .ack_ready(ack_ready),
    .outstanding(out3), .overflow(ovf3)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int edge_n = 0;

  // Scoreboard: per instance, a queue of {earliest visible edge, tag}.
  logic [31:0]      exp_q [2][$];
  logic [TAG_W-1:0] last_tag [2];
  logic             ovf_m [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Reference: each accepted tag becomes visible LATENCY edges after
  // acceptance, but only once every older tag has been consumed.
  task automatic model_edge(input logic r, input logic rq, input logic [TAG_W-1:0] t,
                            input logic ar);
    logic [31:0] head;
    logic        vis;
    logic        acc;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        exp_q[k].delete();
        ovf_m[k]    = 1'b0;
        last_tag[k] = '0;
      end else begin
        vis = 1'b0;
        if (exp_q[k].size() > 0) begin
          head = exp_q[k][0];
          vis  = (int'(head[31:4]) <= edge_n);
        end
        acc = rq && (exp_q[k].size() < MAXO);
        if (rq && !acc) ovf_m[k] = 1'b1;
        if (vis && ar) begin
          last_tag[k] = head[3:0];
          void'(exp_q[k].pop_front());
        end
        if (acc) exp_q[k].push_back({28'(edge_n + lat_of(k)), t});
      end
    end
  endtask

  task automatic check_model(input int k);
    logic [31:0] head;
    int          ev;
    int          et;
    ev = 0;
    et = int'(last_tag[k]);
    if (exp_q[k].size() > 0) begin
      head = exp_q[k][0];
      if (int'(head[31:4]) <= edge_n + 1) begin
        ev = 1;
        et = int'(head[3:0]);
      end
    end
    if (k == 0) begin
      chk("L1 ack_valid",   int'(av1),  ev);
      chk("L1 ack_tag",     int'(at1),  et);
      chk("L1 outstanding", int'(out1), exp_q[0].size());
      chk("L1 req_ready",   int'(rdy1), (exp_q[0].size() < MAXO) ? 1 : 0);
      chk("L1 overflow",    int'(ovf1), int'(ovf_m[0]));
    end else begin
      chk("L3 ack_valid",   int'(av3),  ev);
      chk("L3 ack_tag",     int'(at3),  et);
      chk("L3 outstanding", int'(out3), exp_q[1].size());
      chk("L3 req_ready",   int'(rdy3), (exp_q[1].size() < MAXO) ? 1 : 0);
      chk("L3 overflow",    int'(ovf3), int'(ovf_m[1]));
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model, check both DUTs.
  task automatic step(input logic r, input logic rq, input logic [TAG_W-1:0] t,
                      input logic ar);
    rst       = r;
    req       = rq;
    req_tag   = t;
    ack_ready = ar;
    @(posedge clk);
    edge_n++;
    model_edge(r, rq, t, ar);
    #1;
    check_model(0);
    check_model(1);
  endtask

  typedef struct {
    logic             rst;
    logic             req;
    logic [TAG_W-1:0] tag;
    logic             ar;
    logic             v;
    logic [TAG_W-1:0] at;
    int               o;
    logic             rdy;
    logic             ovf;
  } vec_t;

  vec_t tbl [15];

  initial begin
    ovf_m[0] = 1'b0;  ovf_m[1] = 1'b0;
    last_tag[0] = '0; last_tag[1] = '0;

    // Expected LATENCY=1 outputs just after each edge (rows 0-4: single
    // request; rows 5-14: fill with drops, then drain in order).
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b1,  1'b0, 4'h0, 0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'h0, 1'b1,  1'b0, 4'h0, 0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'h5, 1'b1,  1'b1, 4'h5, 1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'h0, 1'b1,  1'b0, 4'h5, 0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'h0, 1'b1,  1'b0, 4'h5, 0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'h0, 1'b0,  1'b1, 4'h0, 1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'h1, 1'b0,  1'b1, 4'h0, 2, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'h2, 1'b0,  1'b1, 4'h0, 3, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'h3, 1'b0,  1'b1, 4'h0, 4, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'h4, 1'b0,  1'b1, 4'h0, 4, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'h5, 1'b0,  1'b1, 4'h0, 4, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b1,  1'b1, 4'h1, 3, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'h0, 1'b1,  1'b1, 4'h2, 2, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 1'b1,  1'b1, 4'h3, 1, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 1'b1,  1'b0, 4'h3, 0, 1'b1, 1'b1};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].tag, tbl[i].ar);
      chk("tbl ack_valid",   int'(av1),  int'(tbl[i].v));
      chk("tbl ack_tag",     int'(at1),  int'(tbl[i].at));
      chk("tbl outstanding", int'(out1), tbl[i].o);
      chk("tbl req_ready",   int'(rdy1), int'(tbl[i].rdy));
      chk("tbl overflow",    int'(ovf1), int'(tbl[i].ovf));
    end

    // LATENCY=3: requests on edges 2,3,4 with tags 1,2,3 -> acks at 5,6,7.
    step(1'b1, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 4'h1, 1'b1);
    step(1'b0, 1'b1, 4'h2, 1'b1);
    step(1'b0, 1'b1, 4'h3, 1'b1);
    chk("lat3 peak outstanding", int'(out3), 3);
    chk("lat3 first ack", int'(av3), 1);
    chk("lat3 first tag", int'(at3), 1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("lat3 second tag", int'(at3), 2);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("lat3 third tag", int'(at3), 3);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("lat3 drained", int'(av3), 0);

    // Three buffered acks drained with ack_ready toggling every cycle.
    step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'hA, 1'b0);
    step(1'b0, 1'b1, 4'hB, 1'b0);
    step(1'b0, 1'b1, 4'hC, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'h0, logic'(i % 2));

    // Simultaneous accept and consume at outstanding=2.
    step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h7, 1'b0);
    step(1'b0, 1'b1, 4'h8, 1'b0);
    step(1'b0, 1'b1, 4'h9, 1'b1);
    chk("accept+consume outstanding", int'(out1), 2);
    chk("accept+consume next tag", int'(at1), 8);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, 1'b1);

    // Reset with requests in flight: none of them is ever acknowledged.
    step(1'b1, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 4'h1, 1'b1);
    step(1'b0, 1'b1, 4'h2, 1'b1);
    step(1'b0, 1'b1, 4'h3, 1'b1);
    step(1'b1, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b1);
      chk("post-reset no ack", int'(av3), 0);
    end
    step(1'b0, 1'b1, 4'h6, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("post-reset new ack", int'(av3), 1);
    chk("post-reset new tag", int'(at3), 6);
    step(1'b0, 1'b0, 4'h0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 199) == 0),
           logic'($urandom_range(0, 99) < 60),
           TAG_W'($urandom_range(0, 15)),
           logic'($urandom_range(0, 99) < 65));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
